primitive_assembler: RTL and testbench
======================================

Name: primitive_assembler

Overview:
- Sits between the instruction-decode stage and the rasterizer.
- Consumes decode's per-cycle vertex/primitive event strobes and groups vertices into points, lines or triangles according to the active primitive type.
- Emits one assembled primitive per valid/ready handshake.
- Back-pressures decode through Stall. Decode holds its registered outputs while Stall is high.

Parameters:
- VERT_WIDTH, 32, width of one packed vertex (X=[15:0], Y=[31:16]).
- CNT_WIDTH, 16, width of the per-primitive-block emitted-primitive counter.

Ports:
- CLK  input  1  clock; all state changes on rising edge.
- RESET  input  1  synchronous, active-high reset.
- StartPrimitive  input  1  decode strobe: begin primitive block.
- PrimitiveType  input  4  type, valid with StartPrimitive.
- NewVertex  input  1  decode strobe: Vertex is valid.
- Vertex  input  VERT_WIDTH  vertex data.
- EndPrimitive  input  1  decode strobe: end primitive block.
- Draw  input  1  decode strobe: flush frame.
- Stall  output  1  back-pressure to decode.
- Prim_Valid  output  1  assembled primitive available.
- Prim_Ready  input  1  rasterizer accepts primitive.
- Prim_V0, Prim_V1, Prim_V2  output  VERT_WIDTH each  primitive vertices; unused slots are 0.
- Prim_Type  output  4  type of the emitted primitive.
- Prim_Num  output  CNT_WIDTH  index of the emitted primitive within its block, 0-based.
- Draw_Out  output  1  one-cycle draw pulse to the rasterizer.
- Busy  output  1  high while in COLLECT.
- Error  output  1  sticky protocol error.

Behaviour:
- Reset: all outputs 0, state IDLE, vertex buffer and counters cleared. A pending Prim_Valid is dropped. Reset has priority over everything.
- Stall is combinational: Stall = Prim_Valid.
- Input events are sampled only on edges where Prim_Valid=0. While Stall=1, inputs are ignored; decode holds and re-presents them.
- Handshake:
  - Prim_Valid stays high, with Prim_* stable, until sampled with Prim_Ready=1.
  - Prim_Valid clears on that edge.
  - No new event is consumed on the same edge.
- Strobe priority (at most one strobe is expected per cycle): StartPrimitive > NewVertex > EndPrimitive > Draw. If more than one is high, only the highest is acted on and Error is set.
- Types and vertices per primitive N:
  - 0 point, N=1
  - 1 line, N=2
  - 2 triangle, N=3
  - 3 line strip, N=2, keep last vertex
  - 4 triangle strip, N=3, keep last two
  - 5 triangle fan, N=3, keep first and last
- Types 6-15: Error set; state enters COLLECT with a discard flag. Vertices are ignored until EndPrimitive or StartPrimitive.
- FSM states: IDLE, COLLECT.
  - IDLE + StartPrimitive -> COLLECT. Latch type, clear vertex count and Prim_Num counter.
  - IDLE + NewVertex -> Error set, vertex ignored.
  - IDLE + EndPrimitive -> Error set, no state change.
  - IDLE + Draw -> Draw_Out=1 for exactly the next cycle.
  - COLLECT + NewVertex:
    - Store the vertex and increment the held-vertex count.
    - When the count reaches N, assert Prim_Valid after the same edge (latency 1 cycle from the sampled strobe).
    - Update the buffer per the type retention rule above.
  - COLLECT + EndPrimitive -> IDLE. A partial primitive is discarded silently, with no Error.
  - COLLECT + StartPrimitive -> implicit end: discard the partial primitive, restart COLLECT with the new type.
  - COLLECT + Draw -> Error set, Draw ignored.
- Vertex ordering:
  - Lists emit in arrival order.
  - Triangle strip, triangle k (0-based) from vertices v[k..k+2]:
    - k even: (v[k], v[k+1], v[k+2]).
    - k odd: (v[k+1], v[k], v[k+2]), which preserves winding.
  - Fan: (v[0], v[k+1], v[k+2]).
- Prim_Num:
  - Equals the block's count of primitives before this one.
  - The counter saturates at all-ones; the output holds all-ones thereafter and does not wrap.
- Prim_Type equals the latched block type.
- Error is sticky until RESET.

Test Plan:
- Reset then StartPrimitive type=2, then three NewVertex with Vertex=1,2,3 -> Prim_Valid high the cycle after the third vertex, V0/V1/V2=1/2/3, Prim_Num=0, Stall=1. Prim_Ready=1 -> Prim_Valid and Stall low next cycle.
- Type 4 strip, vertices 10,11,12,13 with Prim_Ready tied 1 -> two primitives: (10,11,12) Prim_Num=0, then (12,11,13) Prim_Num=1.
- Type 5 fan, vertices 5,6,7,8 -> (5,6,7) then (5,7,8).
- Hold Prim_Ready=0 for 4 cycles after a completed line while decode presents NewVertex=9 -> outputs stable, Stall=1 throughout, vertex 9 consumed only after Prim_Valid clears.
- Type 2 with two vertices, then EndPrimitive, then Draw -> no Prim_Valid, Error=0, Draw_Out single-cycle pulse one cycle after Draw.
- NewVertex in IDLE, or StartPrimitive type=9 -> Error=1 and stays 1. Reset asserted mid-collect with one vertex held -> all outputs 0 next cycle, Error=0.

Source files
------------

// File: rtl/primitive_assembler_if.sv
// Primitive output channel between the assembler and the rasterizer.
// Valid/ready handshake plus the assembled primitive payload.
interface primitive_assembler_if #(
  parameter int VERT_WIDTH = 32,
  parameter int CNT_WIDTH  = 16
) ();

  logic                  Prim_Valid;
  logic                  Prim_Ready;
  logic [VERT_WIDTH-1:0] Prim_V0;
  logic [VERT_WIDTH-1:0] Prim_V1;
  logic [VERT_WIDTH-1:0] Prim_V2;
  logic [3:0]            Prim_Type;
  logic [CNT_WIDTH-1:0]  Prim_Num;

  // Assembler side: produces primitives, observes ready.
  modport master (
    output Prim_Valid,
    output Prim_V0,
    output Prim_V1,
    output Prim_V2,
    output Prim_Type,
    output Prim_Num,
    input  Prim_Ready
  );

  // Rasterizer side: consumes primitives, drives ready.
  modport slave (
    input  Prim_Valid,
    input  Prim_V0,
    input  Prim_V1,
    input  Prim_V2,
    input  Prim_Type,
    input  Prim_Num,
    output Prim_Ready
  );

endinterface

// File: rtl/primitive_assembler.sv
// Primitive assembler: groups decoded vertices into points, lines or
// triangles (lists, strips, fans) and hands them to the rasterizer over a
// valid/ready channel. Decode is back-pressured while a primitive is pending.
module primitive_assembler #(
  parameter int VERT_WIDTH = 32,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  CLK,
  input  logic                  RESET,
  input  logic                  StartPrimitive,
  input  logic [3:0]            PrimitiveType,
  input  logic                  NewVertex,
  input  logic [VERT_WIDTH-1:0] Vertex,
  input  logic                  EndPrimitive,
  input  logic                  Draw,
  output logic                  Stall,
  output logic                  Draw_Out,
  output logic                  Busy,
  output logic                  Error,
  primitive_assembler_if.master prim
);

  typedef enum logic [0:0] {
    IDLE    = 1'b0,
    COLLECT = 1'b1
  } state_t;

  typedef enum logic [3:0] {
    PT_POINT  = 4'd0,
    PT_LINE   = 4'd1,
    PT_TRI    = 4'd2,
    PT_LSTRIP = 4'd3,
    PT_TSTRIP = 4'd4,
    PT_FAN    = 4'd5
  } prim_type_t;

  state_t                state_q, state_d;
  logic [3:0]            type_q, type_d;
  logic                  discard_q, discard_d;
  logic [1:0]            cnt_q, cnt_d;
  logic [VERT_WIDTH-1:0] buf0_q, buf0_d;
  logic [VERT_WIDTH-1:0] buf1_q, buf1_d;
  logic                  parity_q, parity_d;
  logic [CNT_WIDTH-1:0]  num_q, num_d;
  logic                  valid_q, valid_d;
  logic [VERT_WIDTH-1:0] v0_q, v0_d;
  logic [VERT_WIDTH-1:0] v1_q, v1_d;
  logic [VERT_WIDTH-1:0] v2_q, v2_d;
  logic [3:0]            ptype_q, ptype_d;
  logic [CNT_WIDTH-1:0]  pnum_q, pnum_d;
  logic                  draw_out_q, draw_out_d;
  logic                  error_q, error_d;

  logic                  emit;
  logic [VERT_WIDTH-1:0] e0, e1, e2;
  logic [2:0]            strobe_cnt;

  // Next-state logic: handshake retirement, strobe decode and vertex grouping.
  always_comb begin
    // NOTE: every signal assigned here gets a default first so no path leaves it unassigned and infers a latch.
    state_d    = state_q;
    type_d     = type_q;
    discard_d  = discard_q;
    cnt_d      = cnt_q;
    buf0_d     = buf0_q;
    buf1_d     = buf1_q;
    parity_d   = parity_q;
    num_d      = num_q;
    valid_d    = valid_q;
    v0_d       = v0_q;
    v1_d       = v1_q;
    v2_d       = v2_q;
    ptype_d    = ptype_q;
    pnum_d     = pnum_q;
    draw_out_d = 1'b0;
    error_d    = error_q;
    emit       = 1'b0;
    e0         = '0;
    e1         = '0;
    e2         = '0;
    strobe_cnt = {2'b00, StartPrimitive} + {2'b00, NewVertex}
               + {2'b00, EndPrimitive} + {2'b00, Draw};

    if (valid_q) begin
      // A pending primitive blocks event intake; acceptance consumes the edge.
      if (prim.Prim_Ready) valid_d = 1'b0;
    end else begin
      if (strobe_cnt > 3'd1) error_d = 1'b1;

      if (StartPrimitive) begin
        // Also acts as an implicit end: any partial primitive is dropped.
        state_d   = COLLECT;
        type_d    = PrimitiveType;
        discard_d = (PrimitiveType > 4'd5);
        cnt_d     = 2'd0;
        num_d     = '0;
        parity_d  = 1'b0;
        if (PrimitiveType > 4'd5) error_d = 1'b1;
      end else if (NewVertex) begin
        if (state_q == IDLE) begin
          error_d = 1'b1;
        end else if (!discard_q) begin
          case (type_q)
            PT_POINT: begin
              emit = 1'b1;
              e0   = Vertex;
            end
            PT_LINE: begin
              if (cnt_q == 2'd0) begin
                buf0_d = Vertex;
                cnt_d  = 2'd1;
              end else begin
                emit  = 1'b1;
                e0    = buf0_q;
                e1    = Vertex;
                cnt_d = 2'd0;
              end
            end
            PT_TRI: begin
              if (cnt_q == 2'd0) begin
                buf0_d = Vertex;
                cnt_d  = 2'd1;
              end else if (cnt_q == 2'd1) begin
                buf1_d = Vertex;
                cnt_d  = 2'd2;
              end else begin
                emit  = 1'b1;
                e0    = buf0_q;
                e1    = buf1_q;
                e2    = Vertex;
                cnt_d = 2'd0;
              end
            end
            PT_LSTRIP: begin
              // The newest vertex starts the next segment.
              buf0_d = Vertex;
              if (cnt_q == 2'd0) begin
                cnt_d = 2'd1;
              end else begin
                emit = 1'b1;
                e0   = buf0_q;
                e1   = Vertex;
              end
            end
            PT_TSTRIP: begin
              if (cnt_q == 2'd0) begin
                buf0_d = Vertex;
                cnt_d  = 2'd1;
              end else if (cnt_q == 2'd1) begin
                buf1_d = Vertex;
                cnt_d  = 2'd2;
              end else begin
                // Odd triangles swap the first two vertices to keep winding.
                emit     = 1'b1;
                e0       = parity_q ? buf1_q : buf0_q;
                e1       = parity_q ? buf0_q : buf1_q;
                e2       = Vertex;
                buf0_d   = buf1_q;
                buf1_d   = Vertex;
                parity_d = ~parity_q;
              end
            end
            PT_FAN: begin
              if (cnt_q == 2'd0) begin
                buf0_d = Vertex;
                cnt_d  = 2'd1;
              end else if (cnt_q == 2'd1) begin
                buf1_d = Vertex;
                cnt_d  = 2'd2;
              end else begin
                // The hub vertex stays in buf0 for the whole block.
                emit   = 1'b1;
                e0     = buf0_q;
                e1     = buf1_q;
                e2     = Vertex;
                buf1_d = Vertex;
              end
            end
            default: ;
          endcase
        end
      end else if (EndPrimitive) begin
        if (state_q == IDLE) begin
          error_d = 1'b1;
        end else begin
          state_d   = IDLE;
          discard_d = 1'b0;
          cnt_d     = 2'd0;
        end
      end else if (Draw) begin
        if (state_q == IDLE) draw_out_d = 1'b1;
        else                 error_d    = 1'b1;
      end

      if (emit) begin
        valid_d = 1'b1;
        v0_d    = e0;
        v1_d    = e1;
        v2_d    = e2;
        ptype_d = type_q;
        pnum_d  = num_q;
        num_d   = (num_q == '1) ? num_q : num_q + 1'b1;
      end
    end
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge CLK) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (RESET) begin
      state_q    <= IDLE;
      type_q     <= '0;
      discard_q  <= 1'b0;
      cnt_q      <= '0;
      // NOTE: the vertex buffer is a handful of flops, not a RAM, so clearing it on reset is cheap and keeps restarts deterministic.
      buf0_q     <= '0;
      buf1_q     <= '0;
      parity_q   <= 1'b0;
      num_q      <= '0;
      valid_q    <= 1'b0;
      v0_q       <= '0;
      v1_q       <= '0;
      v2_q       <= '0;
      ptype_q    <= '0;
      pnum_q     <= '0;
      draw_out_q <= 1'b0;
      error_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      type_q     <= type_d;
      discard_q  <= discard_d;
      cnt_q      <= cnt_d;
      buf0_q     <= buf0_d;
      buf1_q     <= buf1_d;
      parity_q   <= parity_d;
      num_q      <= num_d;
      valid_q    <= valid_d;
      v0_q       <= v0_d;
      v1_q       <= v1_d;
      v2_q       <= v2_d;
      ptype_q    <= ptype_d;
      pnum_q     <= pnum_d;
      draw_out_q <= draw_out_d;
      error_q    <= error_d;
    end
  end

  assign Stall           = valid_q;
  assign Draw_Out        = draw_out_q;
  assign Busy            = (state_q == COLLECT);
  assign Error           = error_q;
  assign prim.Prim_Valid = valid_q;
  assign prim.Prim_V0    = v0_q;
  assign prim.Prim_V1    = v1_q;
  assign prim.Prim_V2    = v2_q;
  assign prim.Prim_Type  = ptype_q;
  assign prim.Prim_Num   = pnum_q;

endmodule

// File: tb/tb_primitive_assembler.sv
// Directed bench for primitive_assembler. A narrow primitive counter is used
// so that counter saturation is reachable in a few cycles.
module tb_primitive_assembler;

  localparam int VW = 32;
  localparam int CW = 3;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          start_primitive = 1'b0;
  logic [3:0]    primitive_type = '0;
  logic          new_vertex = 1'b0;
  logic [VW-1:0] vertex = '0;
  logic          end_primitive = 1'b0;
  logic          draw = 1'b0;
  logic          stall;
  logic          draw_out;
  logic          busy;
  logic          error;

  int n_checks = 0;
  int n_pass   = 0;

  primitive_assembler_if #(.VERT_WIDTH(VW), .CNT_WIDTH(CW)) prim_bus ();

  primitive_assembler #(.VERT_WIDTH(VW), .CNT_WIDTH(CW)) dut (
    .CLK            (clk),
    .RESET          (reset),
    .StartPrimitive (start_primitive),
    .PrimitiveType  (primitive_type),
    .NewVertex      (new_vertex),
    .Vertex         (vertex),
    .EndPrimitive   (end_primitive),
    .Draw           (draw),
    .Stall          (stall),
    .Draw_Out       (draw_out),
    .Busy           (busy),
    .Error          (error),
    .prim           (prim_bus.master)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    assert (got === exp) n_pass++;
    else $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
  endtask

  // Advance one clock; sample point is 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Hold the currently driven strobe until an edge where Stall was low.
  task automatic present();
    int   budget;
    logic was_stalled;
    budget = 20;
    do begin
      was_stalled = stall;
      tick();
      budget--;
    end while (was_stalled && budget > 0);
    check("stall_released", {63'd0, was_stalled}, 64'd0);
  endtask

  task automatic send_start(input logic [3:0] t);
    start_primitive = 1'b1;
    primitive_type  = t;
    present();
    start_primitive = 1'b0;
  endtask

  task automatic send_vertex(input logic [VW-1:0] v);
    new_vertex = 1'b1;
    vertex     = v;
    present();
    new_vertex = 1'b0;
  endtask

  task automatic send_end();
    end_primitive = 1'b1;
    present();
    end_primitive = 1'b0;
  endtask

  task automatic send_draw();
    draw = 1'b1;
    present();
    draw = 1'b0;
  endtask

  task automatic check_prim(input string tag, input logic [VW-1:0] a, input logic [VW-1:0] b,
                            input logic [VW-1:0] c, input logic [CW-1:0] num, input logic [3:0] t);
    check({tag, "_valid"}, {63'd0, prim_bus.Prim_Valid}, 64'd1);
    check({tag, "_v0"},    {32'd0, prim_bus.Prim_V0},    {32'd0, a});
    check({tag, "_v1"},    {32'd0, prim_bus.Prim_V1},    {32'd0, b});
    check({tag, "_v2"},    {32'd0, prim_bus.Prim_V2},    {32'd0, c});
    check({tag, "_num"},   {61'd0, prim_bus.Prim_Num},   {61'd0, num});
    check({tag, "_type"},  {60'd0, prim_bus.Prim_Type},  {60'd0, t});
  endtask

  initial begin
    prim_bus.Prim_Ready = 1'b0;

    // Reset state.
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    check("rst_valid", {63'd0, prim_bus.Prim_Valid}, 64'd0);
    check("rst_stall", {63'd0, stall}, 64'd0);
    check("rst_busy",  {63'd0, busy}, 64'd0);
    check("rst_error", {63'd0, error}, 64'd0);
    check("rst_draw",  {63'd0, draw_out}, 64'd0);

    // Triangle list: single triangle, then accept.
    send_start(4'd2);
    check("tri_busy", {63'd0, busy}, 64'd1);
    send_vertex(32'd1);
    send_vertex(32'd2);
    check("tri_not_yet", {63'd0, prim_bus.Prim_Valid}, 64'd0);
    send_vertex(32'd3);
    check_prim("tri", 32'd1, 32'd2, 32'd3, 3'd0, 4'd2);
    check("tri_stall", {63'd0, stall}, 64'd1);
    prim_bus.Prim_Ready = 1'b1;
    tick();
    prim_bus.Prim_Ready = 1'b0;
    check("tri_acc_valid", {63'd0, prim_bus.Prim_Valid}, 64'd0);
    check("tri_acc_stall", {63'd0, stall}, 64'd0);

    // Triangle strip with ready tied high: odd triangle swaps v0/v1.
    prim_bus.Prim_Ready = 1'b1;
    send_start(4'd4);
    send_vertex(32'd10);
    send_vertex(32'd11);
    send_vertex(32'd12);
    check_prim("strip0", 32'd10, 32'd11, 32'd12, 3'd0, 4'd4);
    send_vertex(32'd13);
    check_prim("strip1", 32'd12, 32'd11, 32'd13, 3'd1, 4'd4);

    // Triangle fan: hub vertex reused.
    send_start(4'd5);
    send_vertex(32'd5);
    send_vertex(32'd6);
    send_vertex(32'd7);
    check_prim("fan0", 32'd5, 32'd6, 32'd7, 3'd0, 4'd5);
    send_vertex(32'd8);
    check_prim("fan1", 32'd5, 32'd7, 32'd8, 3'd1, 4'd5);
    tick();
    prim_bus.Prim_Ready = 1'b0;
    check("fan_acc_valid", {63'd0, prim_bus.Prim_Valid}, 64'd0);

    // Line list under back-pressure while decode holds vertex 9.
    send_start(4'd1);
    send_vertex(32'h20);
    send_vertex(32'h21);
    check_prim("line0", 32'h20, 32'h21, 32'd0, 3'd0, 4'd1);
    new_vertex = 1'b1;
    vertex     = 32'd9;
    for (int i = 0; i < 4; i++) begin
      tick();
      check("bp_stall", {63'd0, stall}, 64'd1);
      check("bp_valid", {63'd0, prim_bus.Prim_Valid}, 64'd1);
      check("bp_v0",    {32'd0, prim_bus.Prim_V0}, 64'h20);
      check("bp_v1",    {32'd0, prim_bus.Prim_V1}, 64'h21);
    end
    prim_bus.Prim_Ready = 1'b1;
    tick();
    prim_bus.Prim_Ready = 1'b0;
    check("bp_acc_valid", {63'd0, prim_bus.Prim_Valid}, 64'd0);
    tick();
    new_vertex = 1'b0;
    check("bp_nine_buffered", {63'd0, prim_bus.Prim_Valid}, 64'd0);
    send_vertex(32'h22);
    check_prim("line1", 32'd9, 32'h22, 32'd0, 3'd1, 4'd1);
    prim_bus.Prim_Ready = 1'b1;
    tick();
    prim_bus.Prim_Ready = 1'b0;

    // Partial triangle discarded by EndPrimitive, then Draw pulse.
    send_start(4'd2);
    send_vertex(32'h30);
    send_vertex(32'h31);
    send_end();
    check("end_busy",  {63'd0, busy}, 64'd0);
    check("end_valid", {63'd0, prim_bus.Prim_Valid}, 64'd0);
    send_draw();
    check("draw_pulse", {63'd0, draw_out}, 64'd1);
    tick();
    check("draw_done",  {63'd0, draw_out}, 64'd0);
    check("draw_error", {63'd0, error}, 64'd0);

    // Points: Prim_Num saturates at all-ones (7 for a 3-bit counter).
    prim_bus.Prim_Ready = 1'b1;
    send_start(4'd0);
    for (int i = 0; i < 9; i++) begin
      send_vertex(32'h40 + i);
      check_prim("point", 32'h40 + i, 32'd0, 32'd0, (i > 7) ? 3'd7 : 3'(i), 4'd0);
    end
    tick();
    prim_bus.Prim_Ready = 1'b0;
    send_end();

    // Protocol errors: vertex in IDLE, then an illegal type.
    send_vertex(32'h77);
    check("idle_vtx_error", {63'd0, error}, 64'd1);
    check("idle_vtx_valid", {63'd0, prim_bus.Prim_Valid}, 64'd0);
    tick();
    tick();
    check("error_sticky", {63'd0, error}, 64'd1);
    send_start(4'd9);
    check("bad_type_busy",  {63'd0, busy}, 64'd1);
    check("bad_type_error", {63'd0, error}, 64'd1);
    send_vertex(32'h78);
    send_vertex(32'h79);
    send_vertex(32'h7a);
    check("bad_type_discard", {63'd0, prim_bus.Prim_Valid}, 64'd0);
    send_end();

    // Reset mid-collect with one vertex held.
    send_start(4'd2);
    send_vertex(32'h50);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("mid_rst_busy",  {63'd0, busy}, 64'd0);
    check("mid_rst_error", {63'd0, error}, 64'd0);
    check("mid_rst_valid", {63'd0, prim_bus.Prim_Valid}, 64'd0);
    check("mid_rst_stall", {63'd0, stall}, 64'd0);
    check("mid_rst_v0",    {32'd0, prim_bus.Prim_V0}, 64'd0);
    check("mid_rst_type",  {60'd0, prim_bus.Prim_Type}, 64'd0);
    send_start(4'd2);
    send_vertex(32'h60);
    send_vertex(32'h61);
    send_vertex(32'h62);
    check_prim("post_rst", 32'h60, 32'h61, 32'h62, 3'd0, 4'd2);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
